// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_pkg : shared widths, arbiter state and memory request record         |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_slot : one-deep request capture with pending flag and ready        |
// | Rev 1.0      : initial release                                             |
// +----------------------------------------------------------------------------+
module mem_req_slot
  import cache_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_valid,
  input  mem_req_t i_req,
  input  logic     i_clear,
  output mem_req_t o_req,
  output logic     o_pend,
  output logic     o_ready,
  output logic     o_proto
);

  mem_req_t r_req;
  logic     r_pend;
  logic     r_ready;
  logic     w_capture;
  logic     w_pend_nxt;

  // Pend is sampled before the edge, so a pulse in the clearing cycle is dropped.
  always_comb begin
    w_capture  = i_valid && !r_pend;
    w_pend_nxt = w_capture || (r_pend && !i_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (w_capture) begin
        r_req <= i_req;
      end
      r_pend  <= w_pend_nxt;
      r_ready <= !w_pend_nxt;
    end
  end

  assign o_req   = r_req;
  assign o_pend  = r_pend;
  assign o_ready = r_ready;
  assign o_proto = i_valid && r_pend;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin share of one memory port by two caches      |
// | Rev 1.0          : initial release                                         |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W      = cache_pkg::ADDR_W,
  parameter int DATA_W      = cache_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq0_rw,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic              rq1_rw,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err,
  output logic              proto_err
);
  import cache_pkg::*;

  localparam int                 c_cnt_w    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic               c_to_en    = (TIMEOUT_CYC != 0);

  mem_req_t                 w_req_in [2];
  mem_req_t                 w_req    [2];
  logic [1:0]               w_valid;
  logic [1:0]               w_clear;
  logic [1:0]               w_pend;
  logic [1:0]               w_ready;
  logic [1:0]               w_proto;
  logic                     w_done;
  logic                     w_timeout;
  logic                     w_pick;

  arb_state_t               r_state;
  logic                     r_grant;
  logic                     r_last_grant;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [DATA_W-1:0]        r_mem_wdata;
  logic                     r_mem_rw;
  logic                     r_mem_valid;
  logic [1:0][DATA_W-1:0]   r_rdata;
  logic                     r_timeout_err;
  logic                     r_proto_err;

  assign w_valid     = {rq1_valid, rq0_valid};
  assign w_req_in[0] = '{addr: rq0_addr, wdata: rq0_wdata, rw: rq0_rw};
  assign w_req_in[1] = '{addr: rq1_addr, wdata: rq1_wdata, rw: rq1_rw};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    mem_req_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[i]),
      .i_req   (w_req_in[i]),
      .i_clear (w_clear[i]),
      .o_req   (w_req[i]),
      .o_pend  (w_pend[i]),
      .o_ready (w_ready[i]),
      .o_proto (w_proto[i])
    );
  end

  // mem_valid is high in the first WAIT_MEM cycle, which masks any early mem_ready.
  always_comb begin
    w_done    = (r_state == WAIT_MEM) && !r_mem_valid && mem_ready;
    w_timeout = c_to_en && (r_state == WAIT_MEM) && !w_done && (r_cnt == c_cnt_last);
    w_clear   = 2'b00;
    if (w_done || w_timeout) begin
      w_clear[r_grant] = 1'b1;
    end
    w_pick = (w_pend == 2'b11) ? !r_last_grant : w_pend[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_rw      <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_rdata       <= '0;
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_mem_valid <= 1'b0;
      r_proto_err <= r_proto_err || (|w_proto);
      case (r_state)
        IDLE: begin
          if (|w_pend) begin
            r_grant     <= w_pick;
            r_mem_addr  <= w_req[w_pick].addr;
            r_mem_wdata <= w_req[w_pick].wdata;
            r_mem_rw    <= w_req[w_pick].rw;
            r_mem_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (w_done) begin
            if (!r_mem_rw) begin
              r_rdata[r_grant] <= mem_rdata;
            end
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_last_grant  <= r_grant;
            r_state       <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rq0_ready   = w_ready[0];
  assign rq1_ready   = w_ready[1];
  assign rq0_rdata   = r_rdata[0];
  assign rq1_rdata   = r_rdata[1];
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_rw      = r_mem_rw;
  assign mem_valid   = r_mem_valid;
  assign timeout_err = r_timeout_err;
  assign proto_err   = r_proto_err;

endmodule
`default_nettype wire
